// File: rtl/hart_sched_pkg.sv
// Shared constants, state encoding and helpers for the hart scheduler.
package hart_sched_pkg;

   localparam int HART_NUM     = 4;
   localparam int HART_ID_W    = 2;
   localparam int HART_STATE_W = 2;

   typedef enum logic [HART_STATE_W-1:0] {
      HART_IDLE   = 2'd0,
      HART_ACTIVE = 2'd1,
      HART_WAIT   = 2'd2
   } hart_state_e;

   function automatic logic [HART_ID_W:0] count_active(input logic [HART_NUM-1:0] mask);
      logic [HART_ID_W:0] n;
      n = '0;
      for (int i = 0; i < HART_NUM; i++) begin
         n = n + {{HART_ID_W{1'b0}}, mask[i]};
      end
      return n;
   endfunction

endpackage

// File: rtl/hart_sched_if.sv
// Command and issue bundle between front-end control and the hart scheduler.
interface hart_sched_if;
   import hart_sched_pkg::*;

   logic                 stall;
   logic                 start_en;
   logic [HART_ID_W-1:0] start_id;
   logic                 kill_en;
   logic [HART_ID_W-1:0] kill_id;
   logic                 wait_en;
   logic [HART_ID_W-1:0] wait_id;
   logic                 wake_en;
   logic [HART_ID_W-1:0] wake_id;
   logic [HART_ID_W-1:0] hart_id;
   logic                 issue_en;
   logic [HART_NUM-1:0]  hart_st;
   logic [HART_ID_W:0]   active_cnt;

   modport master (
      output stall, start_en, start_id, kill_en, kill_id,
             wait_en, wait_id, wake_en, wake_id,
      input  hart_id, issue_en, hart_st, active_cnt
   );

   modport slave (
      input  stall, start_en, start_id, kill_en, kill_id,
             wait_en, wait_id, wake_en, wake_id,
      output hart_id, issue_en, hart_st, active_cnt
   );

endinterface

// File: rtl/hart_sched_rr_pick.sv
// Rotate-priority encoder: first eligible hart after 'last', wrapping back to 'last' itself.
module hart_rr_pick
   import hart_sched_pkg::*;
(
   input  logic [HART_NUM-1:0]  elig,
   input  logic [HART_ID_W-1:0] last,
   output logic [HART_ID_W-1:0] pick,
   output logic                 found
);

   logic [HART_ID_W-1:0] idx;

   // Scan farthest-first so the nearest eligible hart after 'last' overwrites the rest.
   always_comb begin
      pick  = last;
      found = 1'b0;
      idx   = '0;
      for (int k = HART_NUM; k >= 1; k--) begin
         idx = HART_ID_W'((int'(last) + k) % HART_NUM);
         if (elig[idx]) begin
            pick  = idx;
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/hart_sched.sv
// Fine-grained round-robin hart scheduler: per-hart run state plus registered fetch pick.
module hart_sched
   import hart_sched_pkg::*;
(
   input logic         clk,
   input logic         reset,
   hart_sched_if.slave bus
);

   hart_state_e          st_q [HART_NUM];
   hart_state_e          st_d [HART_NUM];
   logic [HART_NUM-1:0]  kill_hit, start_hit, wait_hit, wake_hit;
   logic [HART_NUM-1:0]  elig, next_active;
   logic [HART_ID_W-1:0] last_q, hart_id_q, pick;
   logic                 issue_q, found;
   logic [HART_NUM-1:0]  hart_st_q;
   logic [HART_ID_W:0]   cnt_q;

   always_comb begin
      kill_hit  = '0;
      start_hit = '0;
      wait_hit  = '0;
      wake_hit  = '0;
      for (int i = 0; i < HART_NUM; i++) begin
         kill_hit[i]  = bus.kill_en  && (bus.kill_id  == HART_ID_W'(i));
         start_hit[i] = bus.start_en && (bus.start_id == HART_ID_W'(i));
         wait_hit[i]  = bus.wait_en  && (bus.wait_id  == HART_ID_W'(i));
         wake_hit[i]  = bus.wake_en  && (bus.wake_id  == HART_ID_W'(i));
      end
   end

   // Each command only acts from one source state, so apart from kill they never compete.
   always_comb begin
      elig        = '0;
      next_active = '0;
      for (int i = 0; i < HART_NUM; i++) begin
         st_d[i] = st_q[i];
         case (st_q[i])
            HART_ACTIVE: if (wait_hit[i]) st_d[i] = HART_WAIT;
            HART_WAIT:   if (wake_hit[i]) st_d[i] = HART_ACTIVE;
            default:     st_d[i] = start_hit[i] ? HART_ACTIVE : HART_IDLE;
         endcase
         if (kill_hit[i]) st_d[i] = HART_IDLE;
         elig[i]        = (st_q[i] == HART_ACTIVE) && !kill_hit[i] && !wait_hit[i];
         next_active[i] = (st_d[i] == HART_ACTIVE);
      end
   end

   hart_rr_pick u_pick (
      .elig  (elig),
      .last  (last_q),
      .pick  (pick),
      .found (found)
   );

   // Stall freezes the pick; a stalled issue only survives while its hart stays eligible.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < HART_NUM; i++) begin
            st_q[i] <= (i == 0) ? HART_ACTIVE : HART_IDLE;
         end
         last_q    <= HART_ID_W'(HART_NUM - 1);
         hart_id_q <= '0;
         issue_q   <= 1'b0;
         hart_st_q <= HART_NUM'(1);
         cnt_q     <= (HART_ID_W + 1)'(1);
      end else begin
         st_q      <= st_d;
         hart_st_q <= next_active;
         cnt_q     <= count_active(next_active);
         if (!bus.stall) begin
            if (found) begin
               hart_id_q <= pick;
               last_q    <= pick;
               issue_q   <= 1'b1;
            end else begin
               issue_q   <= 1'b0;
            end
         end else begin
            issue_q <= issue_q && elig[hart_id_q];
         end
      end
   end

   assign bus.hart_id    = hart_id_q;
   assign bus.issue_en   = issue_q;
   assign bus.hart_st    = hart_st_q;
   assign bus.active_cnt = cnt_q;

endmodule
